alu_control_seq: RTL and testbench
==================================

// Module: alu_control_seq
// PURPOSE
//  Registered, handshaked ALU control decoder for the LEGv8 datapath. Decodes ALUop plus the
//  11-bit opcode (instr[31:21]) into an ALU control word. Extends the ALU op set with multi-cycle
//  MUL/UDIV and holds the control word stable until the execute stage consumes it.
//  Sits between the main control unit (ID) and the ALU / iterative mul-div unit (EX).
// PARAMETERS
//  CTRL_W   4   width of ALUCtrl (codes below use the low 4 bits; upper bits zero)
//  OPC_W    11  opcode field width
//  MUL_LAT  3   cycles ALUCtrl is held in BUSY for MUL (>=1)
//  DIV_LAT  8   cycles ALUCtrl is held in BUSY for UDIV (>=1)
//  CNT_W    4   latency counter width; must satisfy 2**CNT_W > max(MUL_LAT,DIV_LAT)
// PORTS
//  CLK       in   1       clock, all state on rising edge
//  Reset     in   1       synchronous, active-high
//  ALUop     in   2       from main control
//  Opcode    in   OPC_W   instr[31:21]
//  InValid   in   1       ALUop/Opcode valid
//  InReady   out  1       decoder can accept
//  ALUCtrl   out  CTRL_W  registered control word
//  OutValid  out  1       ALUCtrl valid for consumer
//  OutReady  in   1       consumer takes ALUCtrl
//  Busy      out  1       multi-cycle op in progress
//  Illegal   out  1       registered with ALUCtrl; high when decode failed
// BEHAVIOUR
//  Decode: ALUop 00 -> 0010 ADD; 01 -> 0111 PASS_B; 11 -> illegal.
//   ALUop 10: ADD 10001011000->0010; SUB 11001011000->0110; AND 10001010000->0000;
//   ORR 10101010000->0001; ORRI 1011001000x->0001; EOR 11001010000->0101;
//   LSL 11010011011->0011; LSR 11010011010->0100; MUL 10011011000->1000 (multi);
//   UDIV 10011010110->1001 (multi); any other opcode -> illegal.
//   Illegal: ALUCtrl=1111, Illegal=1, single-cycle path.
//  States: IDLE, BUSY, HOLD (2-bit). Accept = InValid & InReady.
//   IDLE: InReady=1. Accept single-cycle op -> register ALUCtrl/Illegal, go HOLD.
//     Accept MUL/UDIV -> register ALUCtrl, cnt<=LAT-1, go BUSY.
//   BUSY: InReady=0, Busy=1, OutValid=0, ALUCtrl held. cnt==0 -> HOLD, else cnt<=cnt-1.
//   HOLD: OutValid=1. OutReady=0 -> stay, ALUCtrl/Illegal stable.
//     OutReady=1 & no accept -> IDLE. InReady=OutReady (combinational) in HOLD;
//     OutReady=1 & InValid=1 -> new word accepted same cycle, back-to-back, no bubble.
//  Latency (accept at edge N): single-cycle OutValid from N+1; MUL N+MUL_LAT+1;
//   UDIV N+DIV_LAT+1. Back-to-back single-cycle ops: one word per cycle with OutReady=1.
//  Inputs ignored when not accepted (InValid=0 or InReady=0); no state change.
//  Reset (any state, incl. mid-BUSY): next edge -> IDLE, ALUCtrl=0, Illegal=0, OutValid=0,
//   Busy=0, cnt=0; in-flight op discarded. InReady=1 in the first cycle after reset.
//  Counter never wraps: loaded only on accept, decremented only in BUSY while nonzero.
// TESTING
//  1 Reset then ALUop=00, InValid 1 cycle, OutReady=1 -> next cycle ALUCtrl=0010, OutValid=1, then IDLE.
//  2 ALUop=10 stream ADD,SUB,AND,ORR,ORRI(...001),EOR,LSL,LSR back-to-back, OutReady=1 ->
//    0010,0110,0000,0001,0001,0101,0011,0100 on consecutive cycles, InReady stays 1.
//  3 MUL accepted at edge N, MUL_LAT=3 -> Busy=1 and InReady=0 for 3 cycles, OutValid at N+4
//    with 1000; a new InValid during BUSY is not accepted and causes no state change.
//  4 SUB with OutReady=0 for 5 cycles -> ALUCtrl=0110 and OutValid held stable; InReady=0;
//    OutReady=1 with InValid=1 (ADD) -> next cycle ALUCtrl=0010.
//  5 ALUop=10 Opcode=11111111111 and ALUop=11 -> ALUCtrl=1111, Illegal=1, OutValid=1 next cycle.
//  6 UDIV accepted, Reset asserted mid-BUSY -> next edge all outputs 0, IDLE, InReady=1;
//    ADD after reset decodes normally.

Source files
------------

// File: rtl/alu_control_seq_if.sv
// rtl/alu_control_seq_if.sv - decoder request/response handshake bundle
interface alu_control_seq_if #(
  parameter int CTRL_W = 4,
  parameter int OPC_W  = 11
);
  logic [1:0]        ALUop;
  logic [OPC_W-1:0]  Opcode;
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] ALUCtrl;
  logic              OutValid;
  logic              OutReady;
  logic              Busy;
  logic              Illegal;

  modport master (
    output ALUop, Opcode, InValid, OutReady,
    input  InReady, ALUCtrl, OutValid, Busy, Illegal
  );

  modport slave (
    input  ALUop, Opcode, InValid, OutReady,
    output InReady, ALUCtrl, OutValid, Busy, Illegal
  );
endinterface

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered, handshaked LEGv8 ALU control decoder with multi-cycle MUL/UDIV hold
module alu_control_seq #(
  parameter int CTRL_W  = 4,
  parameter int OPC_W   = 11,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input logic              CLK,
  input logic              Reset,
  alu_control_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        dec_code;
  logic              dec_illegal;
  logic              dec_multi;
  logic              dec_is_div;
  logic              in_ready;
  logic              accept;

  always_comb begin
    dec_code    = 4'b1111;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_is_div  = 1'b0;
    case (bus.ALUop)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0111;
      2'b10: begin
        casez (bus.Opcode)
          11'b10001011000: dec_code = 4'b0010;
          11'b11001011000: dec_code = 4'b0110;
          11'b10001010000: dec_code = 4'b0000;
          11'b10101010000: dec_code = 4'b0001;
          11'b1011001000?: dec_code = 4'b0001;
          11'b11001010000: dec_code = 4'b0101;
          11'b11010011011: dec_code = 4'b0011;
          11'b11010011010: dec_code = 4'b0100;
          11'b10011011000: begin
            dec_code  = 4'b1000;
            dec_multi = 1'b1;
          end
          11'b10011010110: begin
            dec_code   = 4'b1001;
            dec_multi  = 1'b1;
            dec_is_div = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // HOLD forwards the consumer's ready so a draining word and a new one overlap
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.OutReady);
  assign accept   = bus.InValid && in_ready;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          ctrl_d    = CTRL_W'(dec_code);
          illegal_d = dec_illegal;
          if (dec_multi) begin
            state_d     = BUSY;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            cnt_d       = dec_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          end else begin
            state_d     = HOLD;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end
        end else if ((state_q == HOLD) && bus.OutReady) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d     = HOLD;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.ALUCtrl  = ctrl_q;
  assign bus.Illegal  = illegal_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed scoreboard bench for alu_control_seq
module tb_alu_control_seq;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ORRI = 11'b10110010001;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_UDIV = 11'b10011010110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  alu_control_seq_if #(.CTRL_W(4), .OPC_W(11)) bus ();

  alu_control_seq #(
    .CTRL_W(4), .OPC_W(11), .MUL_LAT(3), .DIV_LAT(8), .CNT_W(4)
  ) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  // Expected {Illegal, ALUCtrl} from the opcode table
  function automatic logic [4:0] model(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0111;
    if (op == 2'b11) return 5'b1_1111;
    if (opc == OP_ADD)  return 5'b0_0010;
    if (opc == OP_SUB)  return 5'b0_0110;
    if (opc == OP_AND)  return 5'b0_0000;
    if (opc == OP_ORR)  return 5'b0_0001;
    if (opc[10:1] == 10'b1011001000) return 5'b0_0001;
    if (opc == OP_EOR)  return 5'b0_0101;
    if (opc == OP_LSL)  return 5'b0_0011;
    if (opc == OP_LSR)  return 5'b0_0100;
    if (opc == OP_MUL)  return 5'b0_1000;
    if (opc == OP_UDIV) return 5'b0_1001;
    return 5'b1_1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample at negedge, score the output handshake, advance
  task automatic cyc(input logic [1:0] op, input logic [10:0] opc, input logic iv,
                     input logic ordy, input logic exp_acc);
    logic [4:0] e;
    bus.ALUop    = op;
    bus.Opcode   = opc;
    bus.InValid  = iv;
    bus.OutReady = ordy;
    @(negedge clk);
    chk("accept", {31'd0, iv & bus.InReady}, {31'd0, exp_acc});
    if (bus.OutValid && bus.OutReady) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("alu_ctrl", {28'd0, bus.ALUCtrl}, {28'd0, e[3:0]});
        chk("illegal", {31'd0, bus.Illegal}, {31'd0, e[4]});
      end
    end
    if (exp_acc) sb.push_back(model(op, opc));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ctrl"},  {28'd0, bus.ALUCtrl},  32'd0);
    chk({tag, "_ovld"},  {31'd0, bus.OutValid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.Busy},     32'd0);
    chk({tag, "_ill"},   {31'd0, bus.Illegal},  32'd0);
    chk({tag, "_irdy"},  {31'd0, bus.InReady},  32'd1);
  endtask

  initial begin
    logic [10:0] stream [8];
    stream = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ORRI, OP_EOR, OP_LSL, OP_LSR};
    bus.ALUop = 2'b00; bus.Opcode = '0; bus.InValid = 1'b0; bus.OutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_chk("reset");

    // ALUop 00 single word, then back to idle
    cyc(2'b00, 11'd0, 1'b1, 1'b1, 1'b1);
    chk("t1_ovld", {31'd0, bus.OutValid}, 32'd1);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    chk("t1_idle", {31'd0, bus.OutValid}, 32'd0);

    // Back-to-back R-type stream, one word per cycle
    for (int i = 0; i < 8; i++) cyc(2'b10, stream[i], 1'b1, 1'b1, 1'b1);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    chk("t2_drained", sb.size(), 32'd0);

    // MUL: three BUSY cycles ignoring new requests
    cyc(2'b10, OP_MUL, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_busy", {31'd0, bus.Busy}, 32'd1);
      chk("t3_ovld", {31'd0, bus.OutValid}, 32'd0);
      chk("t3_irdy", {31'd0, bus.InReady}, 32'd0);
      chk("t3_hold", {28'd0, bus.ALUCtrl}, 32'h8);
      cyc(2'b10, OP_ADD, 1'b1, 1'b1, 1'b0);
    end
    chk("t3_done_ovld", {31'd0, bus.OutValid}, 32'd1);
    chk("t3_done_busy", {31'd0, bus.Busy}, 32'd0);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    chk("t3_nochange", {31'd0, bus.OutValid}, 32'd0);

    // SUB held under backpressure, then replaced by ADD without a bubble
    cyc(2'b10, OP_SUB, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_ovld", {31'd0, bus.OutValid}, 32'd1);
      chk("t4_ctrl", {28'd0, bus.ALUCtrl}, 32'h6);
      cyc(2'b10, OP_ADD, 1'b1, 1'b0, 1'b0);
    end
    cyc(2'b10, OP_ADD, 1'b1, 1'b1, 1'b1);
    chk("t4_next", {28'd0, bus.ALUCtrl}, 32'h2);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);

    // Illegal decodes
    cyc(2'b10, 11'h7FF, 1'b1, 1'b1, 1'b1);
    chk("t5_ill_a", {31'd0, bus.Illegal}, 32'd1);
    cyc(2'b11, 11'd0, 1'b1, 1'b1, 1'b1);
    chk("t5_ill_b", {28'd0, bus.ALUCtrl}, 32'hF);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);

    // UDIV aborted by reset mid-BUSY
    cyc(2'b10, OP_UDIV, 1'b1, 1'b1, 1'b1);
    chk("t6_busy", {31'd0, bus.Busy}, 32'd1);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    sb.delete();
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    idle_chk("t6_reset");
    cyc(2'b10, OP_ADD, 1'b1, 1'b1, 1'b1);
    cyc(2'b00, 11'd0, 1'b0, 1'b1, 1'b0);
    chk("final_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
